// File: rtl/gemm_block_sequencer.sv
// GEMM block sequencer: walks C = A x B one LANES-wide block at a time,
// driving A/B SRAM reads and C writes with a LANES-way MAC datapath.
module gemm_block_sequencer #(
  parameter int LANES      = 4,
  parameter int DATA_W     = 8,
  parameter int ACC_W      = 32,
  parameter int DIM_W      = 8,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [DIM_W-1:0]        M_dimmension,
  input  logic [DIM_W-1:0]        K_dimmension,
  input  logic [DIM_W-1:0]        N_dimmension,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic                    read_enable_A,
  output logic [ADDR_WIDTH-1:0]   address_A,
  input  logic [DATA_W-1:0]       data_out_A,
  output logic                    read_enable_B,
  output logic [ADDR_WIDTH-1:0]   address_B,
  input  logic [LANES*DATA_W-1:0] data_out_B,
  output logic                    write_enable_C,
  output logic [ADDR_WIDTH-1:0]   address_C,
  output logic [LANES*ACC_W-1:0]  data_in_C,
  output logic [LANES-1:0]        c_lane_mask
);

  typedef enum logic [2:0] {
    IDLE, ISSUE, DRAIN, WRITE, FIN
  } state_t;

  state_t state, state_nx;

  logic [DIM_W-1:0]      m_dim, k_dim, n_dim;
  logic [DIM_W-1:0]      m_cnt, k_cnt, nb_cnt;
  logic [DIM_W:0]        n_round, nb_dim;
  logic [DIM_W+1:0]      col_base;
  logic [ADDR_WIDTH-1:0] a_addr, a_base, b_addr, c_addr;
  logic                  err_q, acc_vld, acc_first;
  logic                  zero_dim, last_k, last_nb, last_m;
  logic [LANES-1:0]      lane_mask;

  logic [2*DATA_W-1:0]        a_ext;
  logic [2*DATA_W-1:0]        b_ext [LANES];
  logic signed [2*DATA_W-1:0] mul   [LANES];
  logic signed [ACC_W-1:0]    prod  [LANES];
  logic signed [ACC_W-1:0]    acc   [LANES];

  assign zero_dim = (M_dimmension == '0) ||
                    (K_dimmension == '0) ||
                    (N_dimmension == '0);

  // NB = ceil(N / LANES), one extra bit so N + LANES - 1 cannot overflow
  assign n_round = {1'b0, n_dim} + (DIM_W+1)'(LANES - 1);
  assign nb_dim  = n_round / (DIM_W+1)'(LANES);

  assign last_k  = (k_cnt == k_dim - 1'b1);
  assign last_m  = (m_cnt == m_dim - 1'b1);
  assign last_nb = ({1'b0, nb_cnt} == nb_dim - 1'b1);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (in_valid) state_nx = zero_dim ? FIN : ISSUE;
      ISSUE:   if (last_k) state_nx = DRAIN;
      DRAIN:   state_nx = WRITE;
      WRITE:   state_nx = (last_nb && last_m) ? FIN : ISSUE;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      err_q     <= 1'b0;
      acc_vld   <= 1'b0;
      acc_first <= 1'b0;
      m_dim     <= '0;
      k_dim     <= '0;
      n_dim     <= '0;
      m_cnt     <= '0;
      k_cnt     <= '0;
      nb_cnt    <= '0;
      col_base  <= '0;
      a_addr    <= '0;
      a_base    <= '0;
      b_addr    <= '0;
      c_addr    <= '0;
    end else begin
      state     <= state_nx;
      acc_vld   <= (state == ISSUE);
      acc_first <= (state == ISSUE) && (k_cnt == '0);
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            m_dim    <= M_dimmension;
            k_dim    <= K_dimmension;
            n_dim    <= N_dimmension;
            err_q    <= zero_dim;
            m_cnt    <= '0;
            k_cnt    <= '0;
            nb_cnt   <= '0;
            col_base <= '0;
            a_addr   <= '0;
            a_base   <= '0;
            b_addr   <= '0;
            c_addr   <= '0;
          end
        end
        ISSUE: begin
          k_cnt  <= last_k ? '0 : k_cnt + 1'b1;
          a_addr <= a_addr + 1'b1;
          b_addr <= b_addr + ADDR_WIDTH'(nb_dim);
        end
        WRITE: begin
          c_addr <= c_addr + 1'b1;
          if (last_nb) begin
            // a_addr already points at the start of row m+1
            nb_cnt   <= '0;
            m_cnt    <= m_cnt + 1'b1;
            a_base   <= a_addr;
            b_addr   <= '0;
            col_base <= '0;
          end else begin
            nb_cnt   <= nb_cnt + 1'b1;
            a_addr   <= a_base;
            b_addr   <= ADDR_WIDTH'(nb_cnt) + 1'b1;
            col_base <= col_base + (DIM_W+2)'(LANES);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    a_ext = {{DATA_W{data_out_A[DATA_W-1]}}, data_out_A};
    for (int i = 0; i < LANES; i++) begin
      b_ext[i] = {{DATA_W{data_out_B[i*DATA_W+DATA_W-1]}},
                  data_out_B[i*DATA_W +: DATA_W]};
      mul[i]   = $signed(a_ext) * $signed(b_ext[i]);
      prod[i]  = ACC_W'(mul[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LANES; i++) acc[i] <= '0;
    end else if (acc_vld) begin
      for (int i = 0; i < LANES; i++)
        acc[i] <= acc_first ? prod[i] : acc[i] + prod[i];
    end
  end

  always_comb begin
    for (int i = 0; i < LANES; i++)
      lane_mask[i] = (col_base + (DIM_W+2)'(i)) < {2'b00, n_dim};
  end

  // Outputs are forced low while reset is held so an aborted job never writes
  always_comb begin
    busy           = 1'b0;
    done           = 1'b0;
    err            = 1'b0;
    read_enable_A  = 1'b0;
    read_enable_B  = 1'b0;
    write_enable_C = 1'b0;
    address_A      = '0;
    address_B      = '0;
    address_C      = '0;
    data_in_C      = '0;
    c_lane_mask    = '0;
    if (!reset) begin
      unique case (state)
        ISSUE: begin
          busy          = 1'b1;
          read_enable_A = 1'b1;
          read_enable_B = 1'b1;
          address_A     = a_addr;
          address_B     = b_addr;
        end
        DRAIN: busy = 1'b1;
        WRITE: begin
          busy           = 1'b1;
          write_enable_C = 1'b1;
          address_C      = c_addr;
          c_lane_mask    = lane_mask;
          for (int i = 0; i < LANES; i++)
            data_in_C[i*ACC_W +: ACC_W] = lane_mask[i] ? acc[i] : '0;
        end
        FIN: begin
          done = 1'b1;
          err  = err_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gemm_block_sequencer.sv
// Bench for gemm_block_sequencer: SRAM models, random jobs and a
// straight matrix-product reference.
module tb_gemm_block_sequencer;

  logic clk = 1'b0;
  logic reset, in_valid;
  logic [7:0] m_in, k_in, n_in;

  logic busy, done, err;
  logic read_enable_A, read_enable_B, write_enable_C;
  logic [15:0] address_A, address_B, address_C;
  logic [7:0] data_out_A;
  logic [31:0] data_out_B;
  logic [127:0] data_in_C;
  logic [3:0] c_lane_mask;

  logic busy16, done16, err16, re_a16, re_b16, we16;
  logic [15:0] adr_a16, adr_b16, adr_c16;
  logic [63:0] data16;
  logic [3:0] mask16;

  logic signed [7:0] mem_a [1024];
  logic [31:0] mem_b [1024];

  int tests = 0;
  int fails = 0;

  logic [15:0] w_addr[$];
  logic [127:0] w_data[$];
  logic [63:0] w_d16[$];
  logic [3:0] w_mask[$];
  int w_cyc[$];
  int rd_a, rd_b, first_rd, done_cyc, err_cyc, busy_cnt, post_act;
  bit quiet;

  logic [127:0] e_data[$];
  logic [3:0] e_mask[$];

  gemm_block_sequencer dut (
    .clk(clk), .reset(reset), .in_valid(in_valid),
    .M_dimmension(m_in), .K_dimmension(k_in), .N_dimmension(n_in),
    .busy(busy), .done(done), .err(err),
    .read_enable_A(read_enable_A), .address_A(address_A),
    .data_out_A(data_out_A),
    .read_enable_B(read_enable_B), .address_B(address_B),
    .data_out_B(data_out_B),
    .write_enable_C(write_enable_C), .address_C(address_C),
    .data_in_C(data_in_C), .c_lane_mask(c_lane_mask)
  );

  gemm_block_sequencer #(.ACC_W(16)) dut16 (
    .clk(clk), .reset(reset), .in_valid(in_valid),
    .M_dimmension(m_in), .K_dimmension(k_in), .N_dimmension(n_in),
    .busy(busy16), .done(done16), .err(err16),
    .read_enable_A(re_a16), .address_A(adr_a16),
    .data_out_A(data_out_A),
    .read_enable_B(re_b16), .address_B(adr_b16),
    .data_out_B(data_out_B),
    .write_enable_C(we16), .address_C(adr_c16),
    .data_in_C(data16), .c_lane_mask(mask16)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (read_enable_A) data_out_A <= mem_a[address_A[9:0]];
    if (read_enable_B) data_out_B <= mem_b[address_B[9:0]];
  end

  task automatic fill_mem();
    for (int i = 0; i < 1024; i++) begin
      mem_a[i] = 8'($urandom);
      mem_b[i] = $urandom;
    end
  endtask

  task automatic model(input int m, input int k, input int n);
    int nb, s, av, bv;
    logic [127:0] d;
    logic [3:0] mk;
    logic [31:0] word;
    logic signed [7:0] lane;
    nb = (n + 3) / 4;
    e_data.delete();
    e_mask.delete();
    for (int mm = 0; mm < m; mm++)
      for (int b = 0; b < nb; b++) begin
        d = '0;
        mk = '0;
        for (int l = 0; l < 4; l++)
          if (b * 4 + l < n) begin
            s = 0;
            for (int kk = 0; kk < k; kk++) begin
              av = mem_a[mm * k + kk];
              word = mem_b[kk * nb + b];
              lane = word[l*8 +: 8];
              bv = lane;
              s += av * bv;
            end
            d[l*32 +: 32] = s;
            mk[l] = 1'b1;
          end
        e_data.push_back(d);
        e_mask.push_back(mk);
      end
  endtask

  task automatic run_job(input int m, input int k, input int n,
                         input int pulse_at, input int rst_at);
    int lim;
    w_addr.delete(); w_data.delete(); w_d16.delete();
    w_mask.delete(); w_cyc.delete();
    rd_a = 0; rd_b = 0; first_rd = -1; done_cyc = -1;
    err_cyc = -1; busy_cnt = 0; post_act = 0; quiet = 1'b1;
    lim = m * ((n + 3) / 4) * (k + 2) + 8;
    @(negedge clk);
    m_in = 8'(m); k_in = 8'(k); n_in = 8'(n);
    in_valid = 1'b1;
    for (int c = 1; c <= lim; c++) begin
      @(negedge clk);
      in_valid = (c == pulse_at);
      if (c == pulse_at) begin
        m_in = 8'd1; k_in = 8'd1; n_in = 8'd1;
      end
      reset = (c == rst_at);
      #1;
      if (read_enable_A) begin
        rd_a++;
        if (first_rd < 0) first_rd = c;
      end
      if (read_enable_B) rd_b++;
      if (busy) busy_cnt++;
      if (write_enable_C) begin
        w_addr.push_back(address_C);
        w_data.push_back(data_in_C);
        w_d16.push_back(data16);
        w_mask.push_back(c_lane_mask);
        w_cyc.push_back(c);
      end
      if (done && done_cyc < 0) begin
        done_cyc = c;
        if (err) err_cyc = c;
      end else if (done_cyc >= 0 && (busy | done | read_enable_A |
                                     read_enable_B | write_enable_C))
        post_act++;
      if (rst_at > 0 && (c == rst_at || c == rst_at + 1))
        if ({busy, done, err, read_enable_A, read_enable_B, write_enable_C,
             address_A, address_B, address_C, data_in_C, c_lane_mask} != '0)
          quiet = 1'b0;
      if (done_cyc >= 0 && c >= done_cyc + 3) break;
      if (rst_at > 0 && c >= rst_at + 4) break;
    end
    in_valid = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0;
    m_in = '0; k_in = '0; n_in = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1;
    tests++;
    if ({busy, done, err} !== 3'b000) begin
      fails++;
      $display("FAIL reset_status: got %b want 000", {busy, done, err});
    end
    tests++;
    if ({read_enable_A, read_enable_B, write_enable_C} !== 3'b000) begin
      fails++;
      $display("FAIL reset_strobes: got %b want 000",
               {read_enable_A, read_enable_B, write_enable_C});
    end
    tests++;
    if ({address_A, address_B, address_C} !== 48'h0) begin
      fails++;
      $display("FAIL reset_addr: got %h want 0",
               {address_A, address_B, address_C});
    end
    tests++;
    if ({data_in_C, c_lane_mask} !== 132'h0) begin
      fails++;
      $display("FAIL reset_data: got %h want 0", {data_in_C, c_lane_mask});
    end
  endtask

  task automatic test_minimal();
    mem_a[0] = 8'sd3;
    mem_b[0] = {8'h7f, 8'h7f, 8'h7f, 8'hfe};
    run_job(1, 1, 1, -1, -1);
    tests++;
    if (first_rd !== 1 || rd_a !== 1 || rd_b !== 1) begin
      fails++;
      $display("FAIL min_reads: got first=%0d a=%0d b=%0d want 1 1 1",
               first_rd, rd_a, rd_b);
    end
    tests++;
    if (w_addr.size() !== 1) begin
      fails++;
      $display("FAIL min_nwr: got %0d want 1", w_addr.size());
    end else begin
      tests++;
      if (w_cyc[0] !== 3 || w_addr[0] !== 16'h0) begin
        fails++;
        $display("FAIL min_wr: got cyc=%0d addr=%0d want 3 0",
                 w_cyc[0], w_addr[0]);
      end
      tests++;
      if (w_data[0] !== {96'h0, 32'hffff_fffa} || w_mask[0] !== 4'b0001) begin
        fails++;
        $display("FAIL min_data: got %h/%b want fffffffa/0001",
                 w_data[0], w_mask[0]);
      end
    end
    tests++;
    if (done_cyc !== 4 || err_cyc !== -1) begin
      fails++;
      $display("FAIL min_done: got %0d err=%0d want 4 -1", done_cyc, err_cyc);
    end
  endtask

  task automatic test_full();
    fill_mem();
    model(2, 3, 8);
    run_job(2, 3, 8, -1, -1);
    tests++;
    if (w_addr.size() !== 4) begin
      fails++;
      $display("FAIL full_nwr: got %0d want 4", w_addr.size());
    end
    for (int i = 0; i < w_addr.size() && i < 4; i++) begin
      tests++;
      if (w_addr[i] !== 16'(i) || w_cyc[i] !== (i + 1) * 5 ||
          w_data[i] !== e_data[i] || w_mask[i] !== e_mask[i]) begin
        fails++;
        $display("FAIL full_wr%0d: got a=%0d c=%0d d=%h m=%b want %0d %0d %h %b",
                 i, w_addr[i], w_cyc[i], w_data[i], w_mask[i],
                 i, (i + 1) * 5, e_data[i], e_mask[i]);
      end
    end
    tests++;
    if (done_cyc !== 21 || rd_a !== 12 || rd_b !== 12 || busy_cnt !== 20) begin
      fails++;
      $display("FAIL full_timing: got done=%0d a=%0d b=%0d busy=%0d want 21 12 12 20",
               done_cyc, rd_a, rd_b, busy_cnt);
    end
  endtask

  task automatic test_random();
    int m, k, n, nb, per, bad;
    for (int it = 0; it < 6; it++) begin
      m = $urandom_range(1, 4);
      k = $urandom_range(1, 6);
      n = $urandom_range(1, 11);
      nb = (n + 3) / 4;
      per = k + 2;
      fill_mem();
      model(m, k, n);
      run_job(m, k, n, -1, -1);
      bad = 0;
      if (w_addr.size() != m * nb) bad = 1;
      else
        for (int i = 0; i < m * nb; i++)
          if (w_addr[i] !== 16'(i) || w_cyc[i] !== (i + 1) * per ||
              w_data[i] !== e_data[i] || w_mask[i] !== e_mask[i])
            bad = 1;
      tests++;
      if (bad) begin
        fails++;
        $display("FAIL rand%0d_wr: M=%0d K=%0d N=%0d got %0d writes want %0d",
                 it, m, k, n, w_addr.size(), m * nb);
      end
      tests++;
      if (done_cyc !== m * nb * per + 1 || rd_a !== m * nb * k) begin
        fails++;
        $display("FAIL rand%0d_time: got done=%0d rd=%0d want %0d %0d",
                 it, done_cyc, rd_a, m * nb * per + 1, m * nb * k);
      end
    end
  endtask

  task automatic test_wrap();
    mem_a[0] = -8'sd128;
    mem_a[1] = -8'sd128;
    mem_b[0] = 32'h8080_8080;
    mem_b[1] = 32'h8080_8080;
    run_job(1, 2, 4, -1, -1);
    tests++;
    if (w_addr.size() !== 1) begin
      fails++;
      $display("FAIL wrap_nwr: got %0d want 1", w_addr.size());
    end else begin
      tests++;
      if (w_data[0] !== {4{32'h0000_8000}} || w_mask[0] !== 4'b1111) begin
        fails++;
        $display("FAIL wrap_acc32: got %h/%b want 4x00008000/1111",
                 w_data[0], w_mask[0]);
      end
      tests++;
      if (w_d16[0] !== {4{16'h8000}}) begin
        fails++;
        $display("FAIL wrap_acc16: got %h want 4x8000", w_d16[0]);
      end
    end
  endtask

  task automatic test_zero_dim();
    run_job(1, 0, 3, -1, -1);
    tests++;
    if (done_cyc !== 1 || err_cyc !== 1) begin
      fails++;
      $display("FAIL zero_done: got done=%0d err=%0d want 1 1",
               done_cyc, err_cyc);
    end
    tests++;
    if (busy_cnt !== 0 || rd_a + rd_b !== 0 || w_addr.size() !== 0 ||
        post_act !== 0) begin
      fails++;
      $display("FAIL zero_quiet: got busy=%0d rd=%0d wr=%0d post=%0d want 0",
               busy_cnt, rd_a + rd_b, w_addr.size(), post_act);
    end
  endtask

  task automatic test_back_to_back_ignore();
    int bad;
    fill_mem();
    model(2, 3, 5);
    run_job(2, 3, 5, 4, -1);
    bad = 0;
    if (w_addr.size() != 4) bad = 1;
    else
      for (int i = 0; i < 4; i++)
        if (w_addr[i] !== 16'(i) || w_data[i] !== e_data[i] ||
            w_mask[i] !== e_mask[i])
          bad = 1;
    tests++;
    if (bad) begin
      fails++;
      $display("FAIL ignore_wr: got %0d writes want 4 matching", w_addr.size());
    end
    tests++;
    if (done_cyc !== 21 || post_act !== 0 || rd_a !== 12) begin
      fails++;
      $display("FAIL ignore_time: got done=%0d post=%0d rd=%0d want 21 0 12",
               done_cyc, post_act, rd_a);
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    fill_mem();
    run_job(2, 3, 4, -1, 4);
    tests++;
    if (w_addr.size() !== 0 || !quiet || done_cyc !== -1) begin
      fails++;
      $display("FAIL rstmid_abort: got wr=%0d quiet=%0d done=%0d want 0 1 -1",
               w_addr.size(), quiet, done_cyc);
    end
    model(1, 2, 6);
    run_job(1, 2, 6, -1, -1);
    bad = 0;
    if (w_addr.size() != 2) bad = 1;
    else
      for (int i = 0; i < 2; i++)
        if (w_addr[i] !== 16'(i) || w_data[i] !== e_data[i] ||
            w_mask[i] !== e_mask[i])
          bad = 1;
    tests++;
    if (bad || done_cyc !== 9) begin
      fails++;
      $display("FAIL rstmid_fresh: got wr=%0d done=%0d want 2 9",
               w_addr.size(), done_cyc);
    end
  endtask

  initial begin
    test_reset();
    test_minimal();
    test_full();
    test_random();
    test_wrap();
    test_zero_dim();
    test_back_to_back_ignore();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
